dds_wave_ctrl: RTL and testbench

Sequencer and arbiter for the DDS waveform table. Owns a phase accumulator that turns a sample-rate strobe into table reads. Shares the single read/write port of the waveform RAM between playback reads and a host loader write stream. Delivers registered samples to the DAC path.

---
 rtl/dds_pkg.sv | 15 +
 rtl/single_port_ram.sv | 23 ++
 rtl/dds_wave_ctrl.sv | 131 +++++++++++++
 tb/tb_dds_wave_ctrl.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/dds_pkg.sv
// Shared definitions for the DDS waveform path: controller state encoding and
// default widths used by the controller and the DAC-path blocks.
package dds_pkg;

  localparam int DDS_DATA_WIDTH = 8;
  localparam int DDS_ADDR_WIDTH = 6;
  localparam int DDS_ACC_WIDTH  = 24;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    RUN  = 2'd2
  } state_t;

endpackage

// File: rtl/single_port_ram.sv
// Single-port waveform RAM: one read or write per cycle, registered read data
// (read-first, so a same-cycle write returns the old word).
module single_port_ram #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 6
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] data,
  output logic [DATA_WIDTH-1:0] q
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  // NOTE: no reset on the array or q - RAM macros have none, and the table
  // must survive a controller reset.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= data;
    q <= mem[addr];
  end

endmodule

// File: rtl/dds_wave_ctrl.sv
// DDS waveform sequencer: phase accumulator playback, read-priority arbitration
// of the table RAM against the host loader, and registered sample delivery.
module dds_wave_ctrl
  import dds_pkg::*;
#(
  parameter int DATA_WIDTH = DDS_DATA_WIDTH,
  parameter int ADDR_WIDTH = DDS_ADDR_WIDTH,
  parameter int ACC_WIDTH  = DDS_ACC_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  tick,
  input  logic [ACC_WIDTH-1:0]  ftw,
  input  logic                  ftw_load,
  input  logic [ADDR_WIDTH-1:0] phase_off,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic [DATA_WIDTH-1:0] sample,
  output logic                  sample_valid,
  output logic                  wrap,
  output logic                  ftw_pending,
  output logic                  busy
);

  state_t                state;
  logic [ACC_WIDTH-1:0]  phase_acc;
  logic [ACC_WIDTH-1:0]  ftw_active;
  logic [ACC_WIDTH-1:0]  ftw_shadow;
  logic [ACC_WIDTH-1:0]  acc_sum;
  logic                  carry;
  logic                  read_cycle;
  logic                  rd_pend;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic                  ram_we;
  logic [DATA_WIDTH-1:0] ram_q;

  assign read_cycle = (state == RUN) && tick;
  assign wr_ready   = !read_cycle;
  assign ram_we     = wr_valid && !read_cycle;

  assign {carry, acc_sum} = {1'b0, phase_acc} + {1'b0, ftw_active};
  assign rd_addr  = phase_acc[ACC_WIDTH-1 -: ADDR_WIDTH] + phase_off;
  assign ram_addr = read_cycle ? rd_addr : wr_addr;

  single_port_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .clk  (clk),
    .we   (ram_we),
    .addr (ram_addr),
    .data (wr_data),
    .q    (ram_q)
  );

  // NOTE: all state uses non-blocking assignments so every register samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      busy  <= 1'b0;
    end else if (stop) begin
      state <= IDLE;
      busy  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: if (start) begin
          state <= ARM;
          busy  <= 1'b1;
        end
        ARM: begin
          state <= RUN;
          busy  <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_acc <= '0;
      wrap      <= 1'b0;
    end else begin
      wrap <= read_cycle && carry;
      if (state == ARM)    phase_acc <= '0;
      else if (read_cycle) phase_acc <= acc_sum;
    end
  end

  // Retune points: any load in IDLE, entry through ARM, and accumulator carry in RUN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ftw_active  <= '0;
      ftw_shadow  <= '0;
      ftw_pending <= 1'b0;
    end else begin
      if (ftw_load) ftw_shadow <= ftw;
      if (state == IDLE) begin
        if (ftw_load) begin
          ftw_active  <= ftw;
          ftw_pending <= 1'b0;
        end
      end else if (state == ARM || (read_cycle && carry)) begin
        if (ftw_load)         ftw_active <= ftw;
        else if (ftw_pending) ftw_active <= ftw_shadow;
        ftw_pending <= 1'b0;
      end else if (ftw_load) begin
        ftw_pending <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_pend      <= 1'b0;
      sample_valid <= 1'b0;
      sample       <= '0;
    end else begin
      rd_pend      <= read_cycle;
      sample_valid <= rd_pend;
      if (rd_pend) sample <= ram_q;
    end
  end

endmodule

// File: tb/tb_dds_wave_ctrl.sv
// Self-checking bench for dds_wave_ctrl: directed scenarios plus random traffic,
// every output compared each cycle against an arithmetic reference model.
module tb_dds_wave_ctrl;

  localparam int      DW    = 8;
  localparam int      AW    = 6;
  localparam int      CW    = 24;
  localparam int      DEPTH = 1 << AW;
  localparam longint  MOD   = 64'd1 << CW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start, stop, tick, ftw_load, wr_valid;
  logic [CW-1:0] ftw;
  logic [AW-1:0] phase_off, wr_addr;
  logic [DW-1:0] wr_data;
  logic          wr_ready, sample_valid, wrap, ftw_pending, busy;
  logic [DW-1:0] sample;

  dds_wave_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ACC_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .tick(tick),
    .ftw(ftw), .ftw_load(ftw_load), .phase_off(phase_off),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .sample(sample), .sample_valid(sample_valid), .wrap(wrap),
    .ftw_pending(ftw_pending), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
  endtask

  // Reference model: 0=idle, 1=armed, 2=running; phase as a plain integer.
  int     m_state;
  longint m_phase, m_active, m_shadow;
  bit     m_pending, m_valid, m_wrap, m_rd_prev;
  int     m_rd_val, m_sample;
  int     m_mem [DEPTH];

  task automatic model_reset();
    m_state = 0; m_phase = 0; m_active = 0; m_shadow = 0; m_pending = 0;
    m_valid = 0; m_wrap = 0; m_rd_prev = 0; m_rd_val = 0; m_sample = 0;
  endtask

  task automatic quiet();
    start = 0; stop = 0; tick = 0; ftw_load = 0; wr_valid = 0;
  endtask

  // One clock with the currently driven inputs; checks outputs after the edge.
  task automatic cycle();
    bit     rd, carry;
    int     addr;
    longint sum;
    #1;
    rd = (m_state == 2) && tick;
    check("wr_ready", wr_ready, !rd);
    if (m_rd_prev) m_sample = m_rd_val;
    m_valid = m_rd_prev;
    carry = 0;
    if (rd) begin
      addr     = int'(((m_phase >> (CW - AW)) + phase_off) % DEPTH);
      m_rd_val = m_mem[addr];
      sum      = m_phase + m_active;
      carry    = (sum >= MOD);
      m_phase  = sum % MOD;
    end else if (wr_valid) begin
      m_mem[wr_addr] = wr_data;
    end
    m_wrap    = carry;
    m_rd_prev = rd;
    if (m_state == 0) begin
      if (ftw_load) begin m_active = ftw; m_pending = 0; end
    end else if (m_state == 1 || carry) begin
      if (ftw_load) m_active = ftw;
      else if (m_pending) m_active = m_shadow;
      m_pending = 0;
    end else if (ftw_load) m_pending = 1;
    if (ftw_load) m_shadow = ftw;
    if (m_state == 1) m_phase = 0;
    if (stop) m_state = 0;
    else if (m_state == 0 && start) m_state = 1;
    else if (m_state == 1) m_state = 2;
    @(posedge clk);
    @(negedge clk);
    check("sample_valid", sample_valid, m_valid);
    check("sample", sample, m_sample);
    check("wrap", wrap, m_wrap);
    check("busy", busy, m_state != 0);
    check("ftw_pending", ftw_pending, m_pending);
  endtask

  int wraps, first, got_first;

  initial begin
    quiet();
    ftw = '0; phase_off = '0; wr_addr = '0; wr_data = '0;
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check("rst_sample", sample, 0);
    check("rst_valid", sample_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_wr_ready", wr_ready, 1);
    check("rst_pending", ftw_pending, 0);
    rst_n = 1'b1;

    // Load the table in IDLE, one write per cycle.
    for (int i = 0; i < DEPTH; i++) begin
      wr_valid = 1; wr_addr = AW'(i); wr_data = DW'(i);
      cycle();
    end
    quiet();

    // Ramp playback at one table step per tick.
    ftw = CW'(1 << 18); ftw_load = 1; cycle(); ftw_load = 0;
    start = 1; cycle(); start = 0;
    wraps = 0;
    tick = 1;
    for (int i = 0; i < 70; i++) begin
      cycle();
      if (wrap) wraps++;
    end
    check("ramp_wraps", wraps, 1);
    tick = 0; cycle();

    // Contention: write stalls under continuous ticks, lands on the idle slot.
    tick = 1; wr_valid = 1; wr_addr = 6'd5; wr_data = 8'hAA;
    repeat (5) cycle();
    tick = 0; cycle();
    wr_valid = 0; tick = 1;
    repeat (66) cycle();

    // Retune mid-cycle: applied only at the next carry.
    ftw = CW'(1 << 19); ftw_load = 1; cycle(); ftw_load = 0;
    check("retune_pending", ftw_pending, 1);
    repeat (80) cycle();
    tick = 0; cycle();

    // Offset and control: start+stop stays idle, ticks before RUN are dropped.
    stop = 1; cycle(); stop = 0;
    ftw = CW'(1 << 18); ftw_load = 1; phase_off = 6'd10; cycle(); ftw_load = 0;
    start = 1; stop = 1; cycle(); start = 0; stop = 0;
    check("start_stop_idle", busy, 0);
    tick = 1; repeat (3) cycle();
    start = 1; cycle(); start = 0;
    got_first = 0; first = -1;
    for (int i = 0; i < 8 && !got_first; i++) begin
      cycle();
      if (sample_valid) begin got_first = 1; first = int'(sample); end
    end
    check("offset_first_sample", first, 10);
    repeat (4) cycle();

    // Asynchronous reset between a read and its sample_valid.
    tick = 0;
    #2 rst_n = 1'b0;
    #1;
    check("arst_valid", sample_valid, 0);
    check("arst_busy", busy, 0);
    check("arst_sample", sample, 0);
    check("arst_wr_ready", wr_ready, 1);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cycle();
    ftw = CW'(1 << 18); ftw_load = 1; cycle(); ftw_load = 0;
    start = 1; cycle(); start = 0;
    tick = 1; repeat (10) cycle();
    quiet();
    cycle();

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      start    = ($urandom_range(0, 15) == 0);
      stop     = ($urandom_range(0, 59) == 0);
      tick     = ($urandom_range(0, 2) != 0);
      ftw_load = ($urandom_range(0, 29) == 0);
      ftw      = CW'($urandom_range(1, 1 << 21));
      wr_valid = ($urandom_range(0, 2) == 0);
      wr_addr  = AW'($urandom);
      wr_data  = DW'($urandom);
      if ($urandom_range(0, 99) == 0) phase_off = AW'($urandom);
      cycle();
    end
    quiet();
    repeat (3) cycle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
